// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch mode controllers.
//   state_t    : controller state encoding (STOP, RUN, CLEAR, VIEW)
//   BTN_*      : bit positions of the button request vector. A higher index
//                means a higher priority: run > clr > lap > view.
//   btn_pick() : keeps only the highest-priority request bit.
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2,
        ST_VIEW  = 2'd3
    } state_t;

    localparam int BTN_N    = 4;
    localparam int BTN_VIEW = 0;
    localparam int BTN_LAP  = 1;
    localparam int BTN_CLR  = 2;
    localparam int BTN_RUN  = 3;

    // Returns a one-hot (or zero) vector holding the highest-priority request.
    function automatic logic [BTN_N-1:0] btn_pick(input logic [BTN_N-1:0] req);
        logic [BTN_N-1:0] grant;
        grant = '0;
        for (int i = BTN_N - 1; i >= 0; i--) begin
            if (req[i] && (grant == '0)) begin
                grant[i] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_buffer.sv
// -----------------------------------------------------------------------------
// lap_buffer
// Circular store of up to LAP_DEPTH lap times.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : capture wr_data into the slot at the write pointer
//   wr_data    : lap time to store
//   clr        : empty the buffer (pointer, count and overflow flag)
//   rd_off     : read offset, 0 = newest lap, 1 = next older, ...
//   rd_data    : stored lap at the offset (combinational read)
//   lap_count  : number of valid laps, saturating at LAP_DEPTH
//   lap_ovf    : sticky, an old lap was overwritten since the last clear
// -----------------------------------------------------------------------------
module lap_buffer #(
    parameter int TIME_W    = 24,
    parameter int LAP_DEPTH = 4,
    parameter int PTR_W     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    parameter int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [TIME_W-1:0] wr_data,
    input  logic              clr,
    input  logic [PTR_W-1:0]  rd_off,
    output logic [TIME_W-1:0] rd_data,
    output logic [CNT_W-1:0]  lap_count,
    output logic              lap_ovf
);

    logic [TIME_W-1:0] mem [LAP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  newest;
    logic [PTR_W-1:0]  rd_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            lap_count <= '0;
            lap_ovf   <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            lap_count <= '0;
            lap_ovf   <= 1'b0;
        end else if (wr_en) begin
            // Explicit wrap so non-power-of-2 depths work.
            wr_ptr <= (wr_ptr == PTR_W'(LAP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (lap_count == CNT_W'(LAP_DEPTH)) begin
                lap_ovf <= 1'b1;
            end else begin
                lap_count <= lap_count + 1'b1;
            end
        end
    end

    // Lap contents need no reset; lap_count says which slots are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Read slot = (wr_ptr - 1 - rd_off) mod LAP_DEPTH, folded by compare.
    // The add-back branch may wrap in PTR_W bits, but the true result is
    // below LAP_DEPTH so the truncated value is still exact.
    always_comb begin
        newest = (wr_ptr == '0) ? PTR_W'(LAP_DEPTH - 1) : wr_ptr - 1'b1;
        if (newest >= rd_off) begin
            rd_slot = newest - rd_off;
        end else begin
            rd_slot = newest + PTR_W'(LAP_DEPTH) - rd_off;
        end
    end

    assign rd_data = mem[rd_slot];

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_lap_ctrl
// Stopwatch run/stop/clear control with lap capture and lap review.
//   clk, rst   : clock, asynchronous active-high reset
//   btn_run    : pulse, toggle run/stop (also leaves review into RUN)
//   btn_clr    : pulse, clear counter and laps
//   btn_lap    : pulse, capture time_in as a lap while running
//   btn_view   : pulse, enter review / step to the next older lap
//   time_in    : live time from the counter datapath
//   run_stop   : counter run enable (state RUN)
//   clear      : registered one-cycle clear pulse to the counter
//   view_mode  : display shows a stored lap (state VIEW)
//   disp_time  : time to display (lap in VIEW, otherwise time_in)
//   lap_num    : 1-based number of the shown lap, 1 = newest, 0 outside VIEW
//   lap_count  : number of valid laps
//   lap_ovf    : sticky lap overwrite flag
//   state_dbg  : current controller state, for observation only
// -----------------------------------------------------------------------------
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W    = 24,
    parameter int LAP_DEPTH = 4,
    localparam int PTR_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int CNT_W    = $clog2(LAP_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_run,
    input  logic              btn_clr,
    input  logic              btn_lap,
    input  logic              btn_view,
    input  logic [TIME_W-1:0] time_in,
    output logic              run_stop,
    output logic              clear,
    output logic              view_mode,
    output logic [TIME_W-1:0] disp_time,
    output logic [PTR_W:0]    lap_num,
    output logic [CNT_W-1:0]  lap_count,
    output logic              lap_ovf,
    output state_t            state_dbg
);

    state_t            state, state_n;
    logic [PTR_W-1:0]  view_off, view_off_n;
    logic [BTN_N-1:0]  req;
    logic [BTN_N-1:0]  grant;
    logic              wr_en;
    logic              buf_clr;
    logic [TIME_W-1:0] rd_data;

    // Mask buttons that mean nothing in the current state first, so that an
    // ignored higher-priority button does not swallow a meaningful lower one.
    always_comb begin
        req = '0;
        case (state)
            ST_STOP: begin
                req[BTN_RUN]  = btn_run;
                req[BTN_CLR]  = btn_clr;
                req[BTN_VIEW] = btn_view && (lap_count != '0);
            end
            ST_RUN: begin
                req[BTN_RUN] = btn_run;
                req[BTN_CLR] = btn_clr;
                req[BTN_LAP] = btn_lap;
            end
            ST_VIEW: begin
                req[BTN_RUN]  = btn_run;
                req[BTN_CLR]  = btn_clr;
                req[BTN_VIEW] = btn_view;
            end
            default: req = '0;
        endcase
    end

    assign grant = btn_pick(req);

    always_comb begin
        state_n    = state;
        view_off_n = view_off;
        wr_en      = 1'b0;
        case (state)
            ST_STOP: begin
                if (grant[BTN_RUN]) begin
                    state_n = ST_RUN;
                end else if (grant[BTN_CLR]) begin
                    state_n = ST_CLEAR;
                end else if (grant[BTN_VIEW]) begin
                    state_n    = ST_VIEW;
                    view_off_n = '0;
                end
            end
            ST_RUN: begin
                if (grant[BTN_RUN]) begin
                    state_n = ST_STOP;
                end else if (grant[BTN_CLR]) begin
                    state_n = ST_CLEAR;
                end else if (grant[BTN_LAP]) begin
                    wr_en = 1'b1;
                end
            end
            ST_VIEW: begin
                if (grant[BTN_RUN]) begin
                    state_n    = ST_RUN;
                    view_off_n = '0;
                end else if (grant[BTN_CLR]) begin
                    state_n = ST_CLEAR;
                end else if (grant[BTN_VIEW]) begin
                    // Oldest lap already shown: leave review.
                    if (CNT_W'(view_off) + 1'b1 == lap_count) begin
                        state_n    = ST_STOP;
                        view_off_n = '0;
                    end else begin
                        view_off_n = view_off + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_n    = ST_STOP;
                view_off_n = '0;
            end
            default: begin
                state_n    = ST_STOP;
                view_off_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_STOP;
            view_off <= '0;
            clear    <= 1'b0;
        end else begin
            state    <= state_n;
            view_off <= view_off_n;
            // High during the first STOP cycle after CLEAR.
            clear    <= (state == ST_CLEAR);
        end
    end

    assign buf_clr = (state == ST_CLEAR);

    lap_buffer #(
        .TIME_W    (TIME_W),
        .LAP_DEPTH (LAP_DEPTH),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
    ) u_lap_buffer (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (time_in),
        .clr       (buf_clr),
        .rd_off    (view_off),
        .rd_data   (rd_data),
        .lap_count (lap_count),
        .lap_ovf   (lap_ovf)
    );

    assign run_stop  = (state == ST_RUN);
    assign view_mode = (state == ST_VIEW);
    assign disp_time = view_mode ? rd_data : time_in;
    assign lap_num   = view_mode ? ((PTR_W + 1)'(view_off) + 1'b1) : '0;
    assign state_dbg = state;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_lap_ctrl
// Directed bench for stopwatch_lap_ctrl (TIME_W=24, LAP_DEPTH=4).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that acted on them.
// -----------------------------------------------------------------------------
module tb_stopwatch_lap_ctrl;
    import stopwatch_pkg::*;

    localparam int TIME_W    = 24;
    localparam int LAP_DEPTH = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              btn_run  = 1'b0;
    logic              btn_clr  = 1'b0;
    logic              btn_lap  = 1'b0;
    logic              btn_view = 1'b0;
    logic [TIME_W-1:0] time_in  = '0;
    logic              run_stop;
    logic              clear;
    logic              view_mode;
    logic [TIME_W-1:0] disp_time;
    logic [2:0]        lap_num;
    logic [2:0]        lap_count;
    logic              lap_ovf;
    state_t            state_dbg;

    int errors = 0;
    int checks = 0;

    stopwatch_lap_ctrl #(
        .TIME_W    (TIME_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .btn_lap   (btn_lap),
        .btn_view  (btn_view),
        .time_in   (time_in),
        .run_stop  (run_stop),
        .clear     (clear),
        .view_mode (view_mode),
        .disp_time (disp_time),
        .lap_num   (lap_num),
        .lap_count (lap_count),
        .lap_ovf   (lap_ovf),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle button combination {run, clr, lap, view}.
    task automatic press(input logic [3:0] b);
        {btn_run, btn_clr, btn_lap, btn_view} = b;
        @(negedge clk);
        {btn_run, btn_clr, btn_lap, btn_view} = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [3:0] B_RUN  = 4'b1000;
    localparam logic [3:0] B_CLR  = 4'b0100;
    localparam logic [3:0] B_LAP  = 4'b0010;
    localparam logic [3:0] B_VIEW = 4'b0001;

    initial begin
        // ---- reset and idle ----
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        time_in = 24'd1234;
        #1;
        check("rst_run_stop", 32'(run_stop), 32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_lap_count", 32'(lap_count), 32'd0);
        check("rst_lap_ovf", 32'(lap_ovf), 32'd0);
        check("rst_view_mode", 32'(view_mode), 32'd0);
        check("rst_lap_num", 32'(lap_num), 32'd0);
        check("rst_disp_pass", 32'(disp_time), 32'd1234);
        @(negedge clk);

        // ---- three laps and a full review ----
        press(B_RUN);
        check("run_on", 32'(run_stop), 32'd1);
        time_in = 24'd100; press(B_LAP);
        time_in = 24'd200; press(B_LAP);
        time_in = 24'd300; press(B_LAP);
        check("three_laps_count", 32'(lap_count), 32'd3);
        check("three_laps_ovf", 32'(lap_ovf), 32'd0);
        press(B_RUN);
        check("stopped", 32'(run_stop), 32'd0);
        time_in = 24'd999;
        press(B_VIEW);
        check("view1_mode", 32'(view_mode), 32'd1);
        check("view1_disp", 32'(disp_time), 32'd300);
        check("view1_num", 32'(lap_num), 32'd1);
        press(B_VIEW);
        check("view2_disp", 32'(disp_time), 32'd200);
        check("view2_num", 32'(lap_num), 32'd2);
        press(B_VIEW);
        check("view3_disp", 32'(disp_time), 32'd100);
        check("view3_num", 32'(lap_num), 32'd3);
        press(B_VIEW);
        check("view_exit_mode", 32'(view_mode), 32'd0);
        check("view_exit_state", 32'(state_dbg), 32'(ST_STOP));
        check("view_exit_disp", 32'(disp_time), 32'd999);
        check("view_exit_num", 32'(lap_num), 32'd0);

        // ---- clear from STOP: CLEAR for one cycle, pulse on the next ----
        press(B_CLR);
        check("clr_stop_state", 32'(state_dbg), 32'(ST_CLEAR));
        check("clr_stop_pulse0", 32'(clear), 32'd0);
        idle(1);
        check("clr_stop_pulse1", 32'(clear), 32'd1);
        check("clr_stop_after", 32'(state_dbg), 32'(ST_STOP));
        check("clr_stop_count", 32'(lap_count), 32'd0);
        idle(1);
        check("clr_stop_pulse2", 32'(clear), 32'd0);

        // ---- overflow: six laps into four slots ----
        press(B_RUN);
        for (int i = 1; i <= 6; i++) begin
            time_in = 24'(i);
            press(B_LAP);
        end
        check("ovf_count", 32'(lap_count), 32'd4);
        check("ovf_flag", 32'(lap_ovf), 32'd1);
        press(B_RUN);
        time_in = 24'd55;
        press(B_VIEW);
        check("ovf_view1", 32'(disp_time), 32'd6);
        press(B_VIEW);
        check("ovf_view2", 32'(disp_time), 32'd5);
        press(B_VIEW);
        check("ovf_view3", 32'(disp_time), 32'd4);
        press(B_VIEW);
        check("ovf_view4", 32'(disp_time), 32'd3);
        check("ovf_view4_num", 32'(lap_num), 32'd4);
        press(B_VIEW);
        check("ovf_view_exit", 32'(view_mode), 32'd0);

        // ---- clear while running ----
        press(B_RUN);
        press(B_CLR);
        check("clr_run_state", 32'(state_dbg), 32'(ST_CLEAR));
        check("clr_run_stop", 32'(run_stop), 32'd0);
        check("clr_run_pulse0", 32'(clear), 32'd0);
        idle(1);
        check("clr_run_pulse1", 32'(clear), 32'd1);
        check("clr_run_count", 32'(lap_count), 32'd0);
        check("clr_run_ovf", 32'(lap_ovf), 32'd0);
        check("clr_run_run", 32'(run_stop), 32'd0);
        idle(1);
        check("clr_run_pulse2", 32'(clear), 32'd0);

        // ---- priority: run beats clr in STOP ----
        press(B_RUN | B_CLR);
        check("prio_run_clr_state", 32'(state_dbg), 32'(ST_RUN));
        idle(1);
        check("prio_run_clr_noclr", 32'(clear), 32'd0);
        // ---- lap beats view in RUN ----
        time_in = 24'd77;
        press(B_LAP | B_VIEW);
        check("prio_lap_view_mode", 32'(view_mode), 32'd0);
        check("prio_lap_view_run", 32'(run_stop), 32'd1);
        check("prio_lap_view_count", 32'(lap_count), 32'd1);
        press(B_RUN);
        time_in = 24'd5;
        press(B_VIEW);
        check("prio_lap_stored", 32'(disp_time), 32'd77);
        // ---- run during VIEW returns to RUN ----
        press(B_RUN);
        check("view_run_state", 32'(state_dbg), 32'(ST_RUN));
        check("view_run_num", 32'(lap_num), 32'd0);
        check("view_run_mode", 32'(view_mode), 32'd0);

        // ---- view with no laps is ignored ----
        press(B_CLR);
        idle(1);
        press(B_VIEW);
        check("view_empty_mode", 32'(view_mode), 32'd0);
        check("view_empty_state", 32'(state_dbg), 32'(ST_STOP));

        // ---- asynchronous reset mid-RUN ----
        press(B_RUN);
        check("pre_rst_run", 32'(run_stop), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_run", 32'(run_stop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", 32'(state_dbg), 32'(ST_STOP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Parametrised next-generation stopwatch control FSM. It adds lap capture and lap review to the run/stop/clear control. It sits between the debounced, edge-detected button pulses and the time-counter/display datapath. It drives run enable and clear to the counter, stores up to LAP_DEPTH lap times in a circular buffer, and selects whether the display shows live time or a stored lap.

Parameters:
TIME_W, 24, width of the time value from the counter datapath
LAP_DEPTH, 4, number of lap slots (>=1, need not be a power of 2)
PTR_W, $clog2(LAP_DEPTH) (min 1), width of slot pointers/offsets (derived, not overridden)
CNT_W, $clog2(LAP_DEPTH+1), width of lap_count (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_run  in  1  one-cycle pulse: toggle run/stop
btn_clr  in  1  one-cycle pulse: clear
btn_lap  in  1  one-cycle pulse: capture lap
btn_view  in  1  one-cycle pulse: enter/step lap review
time_in  in  TIME_W  live time from counter
run_stop  out  1  high while state==RUN
clear  out  1  registered one-cycle clear pulse to counter
view_mode  out  1  high while state==VIEW
disp_time  out  TIME_W  time for display
lap_num  out  PTR_W+1  1-based number of the displayed lap (1=newest), 0 when not in VIEW
lap_count  out  CNT_W  number of valid laps (saturates at LAP_DEPTH)
lap_ovf  out  1  sticky: at least one lap was overwritten since last clear

Behaviour:
- Reset (async): state=STOP, clear=0, lap_count=0, wr_ptr=0, view_off=0, lap_ovf=0. Lap storage contents are don't-care. Reset mid-operation aborts VIEW/CLEAR immediately.
- States: STOP, RUN, CLEAR, VIEW. Encoding comes from the package. Registered state with a combinational next-state block. All defaults hold, no latches.
- Button priority within one cycle: run > clr > lap > view. Only the highest-priority valid button in the current state acts. The rest are dropped, not queued.
- STOP:
  - btn_run -> RUN.
  - btn_clr -> CLEAR.
  - btn_view with lap_count>0 -> VIEW, view_off=0 (newest).
  - btn_view with lap_count==0 is ignored.
  - btn_lap is ignored.
- RUN:
  - btn_run -> STOP.
  - btn_clr -> CLEAR.
  - btn_lap: write time_in (value in that cycle) to slot wr_ptr, stay in RUN.
  - btn_view is ignored.
- VIEW:
  - btn_run -> RUN (exit review, view_off=0).
  - btn_clr -> CLEAR.
  - btn_view: if view_off==lap_count-1 -> STOP, else view_off+1 (next older).
  - btn_lap is ignored.
- CLEAR: transient, exactly one cycle, unconditionally -> STOP. All buttons are ignored.
  - On the transition: clear=1 for exactly the following cycle (the first STOP cycle), then 0.
  - lap_count=0, wr_ptr=0, lap_ovf=0, view_off=0 on that same edge.
  - Counter clear latency: 2 cycles from the btn_clr pulse.
- Lap write:
  - wr_ptr increments and wraps LAP_DEPTH-1 -> 0 by explicit compare.
  - lap_count increments, saturating at LAP_DEPTH.
  - A write when lap_count==LAP_DEPTH overwrites the oldest entry and sets lap_ovf.
  - Written data is readable from the next cycle.
- Read slot for VIEW = (wr_ptr-1-view_off) mod LAP_DEPTH, computed without relying on power-of-2 wrap.
- disp_time: in VIEW = stored lap at the read slot (combinational read of registers), otherwise = time_in (combinational pass-through).
- lap_num = view_off+1 in VIEW, else 0. run_stop and view_mode decode the current state only.

Decomposition:
- Package stopwatch_pkg: state typedef/localparams (STOP, RUN, CLEAR, VIEW) and the button-priority ordering constant. Shared with future mode controllers.
- One sub-module, lap_buffer:
  - LAP_DEPTH x TIME_W register array with wr_ptr, lap_count, lap_ovf.
  - Inputs: wr_en, clr, rd_off.
  - Outputs: rd_data.
- The FSM stays in stopwatch_lap_ctrl.

Test Plan:
- Reset then idle 10 cycles -> run_stop=0, clear=0, lap_count=0, disp_time==time_in. Assert rst mid-RUN -> run_stop=0 in the same cycle.
- btn_run, then btn_lap at time_in=100, 200, 300 -> lap_count=3. btn_run (stop), then btn_view -> disp_time=300, lap_num=1. Two more btn_view -> 200, then 100. Fourth btn_view -> STOP, disp_time==time_in.
- LAP_DEPTH=4: 6 laps with time_in=1..6 -> lap_count=4, lap_ovf=1. VIEW sequence shows 6, 5, 4, 3.
- btn_clr in RUN with 2 laps stored -> CLEAR for 1 cycle. clear high exactly the next cycle only. lap_count=0, lap_ovf=0, run_stop=0.
- Same-cycle btn_run+btn_clr in STOP -> RUN, no clear. Same-cycle btn_lap+btn_view in RUN -> lap captured, no VIEW.
- btn_view in STOP with lap_count=0 -> stays STOP, view_mode=0. btn_run during VIEW -> RUN, lap_num=0.
